scan_capture: RTL

Serial-to-parallel receiver for the debug scan interface: it is the far end of the `scan` transmitter. After an `en` strobe, it samples the 19-bit LSB-first stream on `scan_in` and presents the reassembled word on `data` with a one-cycle `valid` pulse. It sits on the test-harness/loopback side of the toy CPU, so the scan path can be self-checked on chip and external test registers can be loaded through the same one-wire protocol.

---
 rtl/scan_capture.sv | 119 +++++++++++
 1 files changed

// File: rtl/scan_capture.sv
// Serial-to-parallel receiver for the debug scan link: reassembles an LSB-first frame after an en strobe.
// Optional build macro SCAN_CAPTURE_SHADOW_EN adds a holding register so data stays stable between completions.
module scan_capture #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             scan_in,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy,
    output logic             abort
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic             complete;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sr_d     = sr_q;
        valid_d  = 1'b0;
        abort_d  = 1'b0;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SHIFT;
                    count_d = '0;
                end
            end
            SHIFT: begin
                // The last bit always lands, even when en restarts on the same edge.
                if (count_q == LAST_BIT) begin
                    sr_d     = {scan_in, sr_q[WIDTH-1:1]};
                    valid_d  = 1'b1;
                    complete = 1'b1;
                    count_d  = '0;
                    state_d  = en ? SHIFT : IDLE;
                end else if (en) begin
                    abort_d = 1'b1;
                    count_d = '0;
                end else begin
                    sr_d    = {scan_in, sr_q[WIDTH-1:1]};
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            sr_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sr_q    <= sr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

`ifdef SCAN_CAPTURE_SHADOW_EN
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (complete) begin
            data_d = sr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;
`else
    logic unused_complete;
    assign unused_complete = complete;
    assign data = sr_q;
`endif

    assign valid = valid_q;
    assign busy  = busy_q;
    assign abort = abort_q;

endmodule
